// File: rtl/fifo_word_packer_if.sv
// Stream bundle between the packer, the 8-bit FIFO read port and the 16-bit sink.
interface fifo_word_packer_if;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;

  // Packer side: consumes FIFO bytes, produces words.
  modport master (
    input  fifo_empty, fifo_data, word_ready,
    output fifo_rd, word_out, word_valid
  );

  // Environment side: FIFO plus downstream sink.
  modport slave (
    output fifo_empty, fifo_data, word_ready,
    input  fifo_rd, word_out, word_valid
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops byte pairs from a registered-read FIFO, packs them into 16-bit words
// and offers them on a valid/ready stream; counts accepted words.
module fifo_word_packer #(
  parameter bit FIRST_BYTE_HIGH = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  fifo_word_packer_if.master        bus,
  input  logic                      flush,
  output logic                      partial,
  output logic [15:0]               word_count
);

  typedef enum logic [2:0] {RD0, CAP0, RD1, CAP1, OUT} state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        partial_q, partial_d;
  logic [15:0] word_count_q, word_count_d;
  logic        pop;
  logic        handshake;

  assign handshake = (state_q == OUT) && bus.word_ready;

  // Next-state, byte capture and pop request; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    partial_d    = partial_q;
    word_count_d = word_count_q;
    pop          = 1'b0;
    case (state_q)
      RD0: begin
        pop = !bus.fifo_empty;
        if (pop) state_d = CAP0;
      end
      CAP0: begin
        if (FIRST_BYTE_HIGH) word_d[15:8] = bus.fifo_data;
        else                 word_d[7:0]  = bus.fifo_data;
        partial_d = 1'b1;
        state_d   = RD1;
      end
      RD1: begin
        pop = !bus.fifo_empty;
        if (pop) state_d = CAP1;
      end
      CAP1: begin
        if (FIRST_BYTE_HIGH) word_d[7:0]  = bus.fifo_data;
        else                 word_d[15:8] = bus.fifo_data;
        partial_d = 1'b0;
        state_d   = OUT;
      end
      OUT: begin
        if (handshake) state_d = RD0;
      end
      default: state_d = RD0;
    endcase
    // A handshake coinciding with flush is still a delivered word.
    if (handshake) word_count_d = word_count_q + 16'd1;
    // Flush drops any half-built word; a byte landing this cycle is discarded.
    if (flush) begin
      pop       = 1'b0;
      state_d   = RD0;
      partial_d = 1'b0;
      word_d    = word_q;
    end
  end

  // State, word and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RD0;
      word_q       <= 16'h0000;
      partial_q    <= 1'b0;
      word_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      partial_q    <= partial_d;
      word_count_q <= word_count_d;
    end
  end

  // Pop is gated by reset so nothing is requested while held in reset.
  assign bus.fifo_rd    = pop && reset;
  assign bus.word_out   = word_q;
  assign bus.word_valid = (state_q == OUT);
  assign partial        = partial_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: two instances (high-first and
// low-first packing) each fed by a small registered-read FIFO model.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b1;
  logic        partial0, partial1;
  logic [15:0] count0, count1;

  int nvec = 0;
  int nerr = 0;

  fifo_word_packer_if f0();
  fifo_word_packer_if f1();

  // FIFO models: pushes from the stimulus, pops on fifo_rd with one-cycle read latency.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] fdata0 = 8'h00;
  logic [7:0] fdata1 = 8'h00;
  int pushed0 = 0, popped0 = 0, rd_cnt0 = 0;
  int pushed1 = 0, popped1 = 0;

  assign f0.fifo_empty = (pushed0 == popped0);
  assign f0.fifo_data  = fdata0;
  assign f0.word_ready = ready;
  assign f1.fifo_empty = (pushed1 == popped1);
  assign f1.fifo_data  = fdata1;
  assign f1.word_ready = ready;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (f0.fifo_rd) begin
      fdata0  <= q0.pop_front();
      popped0 <= popped0 + 1;
      rd_cnt0 <= rd_cnt0 + 1;
    end
    if (f1.fifo_rd) begin
      fdata1  <= q1.pop_front();
      popped1 <= popped1 + 1;
    end
  end

  fifo_word_packer #(.FIRST_BYTE_HIGH(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(f0.master), .flush(flush),
    .partial(partial0), .word_count(count0)
  );

  fifo_word_packer #(.FIRST_BYTE_HIGH(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(f1.master), .flush(flush),
    .partial(partial1), .word_count(count1)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] b);
    q0.push_back(b);
    pushed0++;
  endtask

  task automatic push1(input logic [7:0] b);
    q1.push_back(b);
    pushed1++;
  endtask

  task automatic test_reset();
    push0(8'h12); push0(8'h34);
    push1(8'h12); push1(8'h34);
    step(); step();
    nvec++; if (f0.fifo_rd !== 1'b0) begin nerr++; $display("FAIL reset_rd0: got %b want 0", f0.fifo_rd); end
    nvec++; if (f1.fifo_rd !== 1'b0) begin nerr++; $display("FAIL reset_rd1: got %b want 0", f1.fifo_rd); end
    nvec++; if (f0.word_out !== 16'h0000) begin nerr++; $display("FAIL reset_word: got %h want 0000", f0.word_out); end
    nvec++; if (f0.word_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", f0.word_valid); end
    nvec++; if (partial0 !== 1'b0) begin nerr++; $display("FAIL reset_partial: got %b want 0", partial0); end
    nvec++; if (count0 !== 16'h0000) begin nerr++; $display("FAIL reset_count: got %h want 0000", count0); end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Cycle 0 is the current cycle (RD0 with data available).
  task automatic test_basic();
    nvec++; if (f0.fifo_rd !== 1'b1) begin nerr++; $display("FAIL basic_pop0: got %b want 1", f0.fifo_rd); end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 2 || c == 3) begin
        nvec++; if (partial0 !== 1'b1) begin nerr++; $display("FAIL basic_partial c%0d: got %b want 1", c, partial0); end
      end
      if (c == 4) begin
        nvec++; if (f0.word_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b want 1", f0.word_valid); end
        nvec++; if (f0.word_out !== 16'h1234) begin nerr++; $display("FAIL basic_word_hi: got %h want 1234", f0.word_out); end
        nvec++; if (f1.word_out !== 16'h3412) begin nerr++; $display("FAIL basic_word_lo: got %h want 3412", f1.word_out); end
        nvec++; if (partial0 !== 1'b0) begin nerr++; $display("FAIL basic_partial_out: got %b want 0", partial0); end
      end
    end
    nvec++; if (count0 !== 16'd1) begin nerr++; $display("FAIL basic_count: got %h want 0001", count0); end
    nvec++; if (count1 !== 16'd1) begin nerr++; $display("FAIL basic_count_lo: got %h want 0001", count1); end
    nvec++; if (f0.word_valid !== 1'b0) begin nerr++; $display("FAIL basic_valid_drop: got %b want 0", f0.word_valid); end
    nvec++; if (rd_cnt0 !== 2) begin nerr++; $display("FAIL basic_pops: got %0d want 2", rd_cnt0); end
  endtask

  task automatic test_gap();
    push0(8'hAB);
    #1;
    nvec++; if (f0.fifo_rd !== 1'b1) begin nerr++; $display("FAIL gap_pop0: got %b want 1", f0.fifo_rd); end
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      nvec++; if (partial0 !== 1'b1) begin nerr++; $display("FAIL gap_partial c%0d: got %b want 1", c, partial0); end
      nvec++; if (f0.fifo_rd !== 1'b0) begin nerr++; $display("FAIL gap_rd c%0d: got %b want 0", c, f0.fifo_rd); end
    end
    push0(8'hCD);
    #1;
    nvec++; if (f0.fifo_rd !== 1'b1) begin nerr++; $display("FAIL gap_resume: got %b want 1", f0.fifo_rd); end
    step(); step();
    nvec++; if (f0.word_out !== 16'hABCD) begin nerr++; $display("FAIL gap_word: got %h want abcd", f0.word_out); end
    step();
    nvec++; if (count0 !== 16'd2) begin nerr++; $display("FAIL gap_count: got %h want 0002", count0); end
  endtask

  task automatic test_backpressure();
    int rc;
    ready = 1'b0;
    push0(8'h5A); push0(8'hA5);
    repeat (4) step();
    nvec++; if (f0.word_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b want 1", f0.word_valid); end
    nvec++; if (f0.word_out !== 16'h5AA5) begin nerr++; $display("FAIL bp_word: got %h want 5aa5", f0.word_out); end
    push0(8'h11); push0(8'h22);
    rc = rd_cnt0;
    for (int c = 0; c < 8; c++) begin
      step();
      nvec++; if (f0.word_out !== 16'h5AA5 || f0.word_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold c%0d: got %h/%b want 5aa5/1", c, f0.word_out, f0.word_valid); end
      nvec++; if (f0.fifo_rd !== 1'b0) begin nerr++; $display("FAIL bp_rd c%0d: got %b want 0", c, f0.fifo_rd); end
    end
    nvec++; if (rd_cnt0 !== rc) begin nerr++; $display("FAIL bp_pops: got %0d want %0d", rd_cnt0, rc); end
    nvec++; if (count0 !== 16'd2) begin nerr++; $display("FAIL bp_count_stall: got %h want 0002", count0); end
    ready = 1'b1;
    step();
    nvec++; if (count0 !== 16'd3) begin nerr++; $display("FAIL bp_count_release: got %h want 0003", count0); end
    step();
    nvec++; if (count0 !== 16'd3) begin nerr++; $display("FAIL bp_count_single: got %h want 0003", count0); end
    repeat (3) step();
    nvec++; if (f0.word_out !== 16'h1122) begin nerr++; $display("FAIL bp_next_word: got %h want 1122", f0.word_out); end
    step();
    nvec++; if (count0 !== 16'd4) begin nerr++; $display("FAIL bp_count_next: got %h want 0004", count0); end
  endtask

  task automatic test_flush();
    push0(8'h55);
    step(); step();
    nvec++; if (partial0 !== 1'b1) begin nerr++; $display("FAIL flush_partial_pre: got %b want 1", partial0); end
    push0(8'h66); push0(8'h77);
    flush = 1'b1;
    #1;
    nvec++; if (f0.fifo_rd !== 1'b0) begin nerr++; $display("FAIL flush_rd: got %b want 0", f0.fifo_rd); end
    step();
    flush = 1'b0;
    nvec++; if (partial0 !== 1'b0) begin nerr++; $display("FAIL flush_partial_post: got %b want 0", partial0); end
    nvec++; if (count0 !== 16'd4) begin nerr++; $display("FAIL flush_count: got %h want 0004", count0); end
    #1;
    nvec++; if (f0.fifo_rd !== 1'b1) begin nerr++; $display("FAIL flush_resume: got %b want 1", f0.fifo_rd); end
    repeat (4) step();
    nvec++; if (f0.word_out !== 16'h6677) begin nerr++; $display("FAIL flush_word: got %h want 6677", f0.word_out); end
    // Flush together with an accepting sink: the word still counts.
    flush = 1'b1;
    step();
    flush = 1'b0;
    nvec++; if (count0 !== 16'd5) begin nerr++; $display("FAIL flush_hs_count: got %h want 0005", count0); end
    nvec++; if (f0.word_valid !== 1'b0) begin nerr++; $display("FAIL flush_hs_valid: got %b want 0", f0.word_valid); end
  endtask

  // The count is preloaded by force rather than by 65535 real transfers
  // to keep the run short.
  task automatic test_wrap();
    force dut0.word_count_q = 16'hFFFE;
    step();
    release dut0.word_count_q;
    nvec++; if (count0 !== 16'hFFFE) begin nerr++; $display("FAIL wrap_preload: got %h want fffe", count0); end
    push0(8'h01); push0(8'h02);
    repeat (4) step();
    nvec++; if (f0.word_out !== 16'h0102) begin nerr++; $display("FAIL wrap_word1: got %h want 0102", f0.word_out); end
    step();
    nvec++; if (count0 !== 16'hFFFF) begin nerr++; $display("FAIL wrap_count_ffff: got %h want ffff", count0); end
    ready = 1'b0;
    push0(8'h03); push0(8'h04);
    repeat (4) step();
    nvec++; if (f0.word_valid !== 1'b1) begin nerr++; $display("FAIL wrap_out_state: got %b want 1", f0.word_valid); end
    push0(8'h77);
    reset = 1'b0;
    #1;
    nvec++; if (f0.word_out !== 16'h0000) begin nerr++; $display("FAIL rst_word: got %h want 0000", f0.word_out); end
    nvec++; if (f0.word_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", f0.word_valid); end
    nvec++; if (partial0 !== 1'b0) begin nerr++; $display("FAIL rst_partial: got %b want 0", partial0); end
    nvec++; if (count0 !== 16'h0000) begin nerr++; $display("FAIL rst_count: got %h want 0000", count0); end
    nvec++; if (f0.fifo_rd !== 1'b0) begin nerr++; $display("FAIL rst_rd: got %b want 0", f0.fifo_rd); end
    step();
    reset = 1'b1;
    ready = 1'b1;
    #1;
    // Pop of 0x77 happens this cycle; count parked at 0xFFFF meanwhile.
    force dut0.word_count_q = 16'hFFFF;
    step();
    release dut0.word_count_q;
    nvec++; if (count0 !== 16'hFFFF) begin nerr++; $display("FAIL wrap_preload2: got %h want ffff", count0); end
    push0(8'h78);
    repeat (3) step();
    nvec++; if (f0.word_out !== 16'h7778) begin nerr++; $display("FAIL wrap_word2: got %h want 7778", f0.word_out); end
    step();
    nvec++; if (count0 !== 16'h0000) begin nerr++; $display("FAIL wrap_rollover: got %h want 0000", count0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the 8-bit FIFO. It pops bytes from the FIFO read port without ever reading an empty FIFO, packs each pair of bytes into a 16-bit word, and presents the word on a valid/ready stream to the next stage. It sits between the FIFO's `data_out`/`rd`/`fifo_empty` and any 16-bit sink. It also keeps a running count of delivered words.

## Interface
Parameters:
- `FIRST_BYTE_HIGH`, default 1: 1 = first popped byte goes to `word_out[15:8]`; 0 = first byte goes to `word_out[7:0]`.

Ports:
- `clk`  input  1  Single clock; all logic on its rising edge.
- `reset`  input  1  Asynchronous, active-low reset.
- `fifo_empty`  input  1  Empty flag from the FIFO.
- `fifo_data`  input  8  FIFO `data_out`. Valid the cycle after `fifo_rd` is high (registered read).
- `fifo_rd`  output  1  Pop request to the FIFO `rd` input.
- `flush`  input  1  Synchronous; discards any partial or pending word.
- `word_out`  output  16  Packed word.
- `word_valid`  output  1  `word_out` holds a word.
- `word_ready`  input  1  Sink accepts the word when high together with `word_valid`.
- `partial`  output  1  First byte captured; second not yet captured.
- `word_count`  output  16  Number of words accepted by the sink. Wraps modulo 2^16.

## Operation
- FSM states: RD0, CAP0, RD1, CAP1, OUT. Reset state is RD0.
- RD0:
  - `fifo_rd` = !`fifo_empty`.
  - If a pop is issued, go to CAP0; otherwise stay in RD0.
- CAP0:
  - Latch `fifo_data` into the first-byte half selected by `FIRST_BYTE_HIGH`.
  - Set `partial` = 1.
  - Go to RD1.
- RD1: same as RD0, but goes to CAP1 on a pop. `partial` stays 1 while waiting.
- CAP1:
  - Latch `fifo_data` into the other half.
  - Clear `partial`.
  - Go to OUT.
- OUT:
  - `word_valid` = 1 and `word_out` is held stable.
  - `fifo_rd` = 0.
  - On `word_valid && word_ready`: increment `word_count` and go to RD0.
- `fifo_rd` is combinational from state and `fifo_empty`. It is forced to 0 while `reset` is low. It is never high in CAP0, CAP1 or OUT, so at most one pop is outstanding and the FIFO is never underflowed by this block.
- `flush` has priority over all normal transitions:
  - Next state is RD0; `partial` clears.
  - `word_valid` is low from the next cycle.
  - A handshake that completes in the same cycle as `flush` still counts and increments `word_count`.
  - A byte popped in the cycle before `flush` (FSM in CAP0/CAP1 during `flush`) is consumed from the FIFO and discarded.
  - While `flush` is high, `fifo_rd` = 0.
- `word_count` rolls over 0xFFFF → 0x0000 with no flag.

## Timing
- Reset values (asynchronous, immediate on `reset` low):
  - state = RD0
  - `word_out` = 0x0000
  - `word_valid` = 0
  - `partial` = 0
  - `word_count` = 0
  - `fifo_rd` = 0
- FIFO non-empty throughout, sink always ready:
  - Cycle 0: pop (RD0).
  - Cycle 1: capture byte 0.
  - Cycle 2: pop (RD1).
  - Cycle 3: capture byte 1.
  - Cycle 4: `word_valid` = 1.
  - Cycle 5: back in RD0.
  - Peak throughput is one word per 5 cycles.
- Empty FIFO stalls the FSM in RD0/RD1 indefinitely with no pops issued. Popping resumes in the same cycle `fifo_empty` falls.
- Backpressure: `word_valid` remains high and `word_out` is unchanged until `word_ready`. No pops occur during the stall.
- `word_count` updates the cycle after the handshake.
- Reset asserted mid-word drops the partial word. Any pop issued in the reset-assertion cycle is the FIFO's concern; this block ignores the returned byte.

## Test plan
- `FIRST_BYTE_HIGH`=1, FIFO holds 0x12, 0x34, sink ready:
  - -> exactly two `fifo_rd` pulses.
  - -> `word_out`=0x1234 with `word_valid` high in cycle 4.
  - -> `word_count`=1.
- `FIRST_BYTE_HIGH`=0, same bytes -> `word_out`=0x3412.
- FIFO holds only 0xAB, then stays empty for 10 cycles, then 0xCD arrives:
  - -> `partial`=1 and `fifo_rd`=0 throughout the gap.
  - -> then `word_out`=0xABCD.
- `word_ready` low for 8 cycles while `word_valid` is high:
  - -> `word_out` stable.
  - -> no `fifo_rd`.
  - -> single `word_count` increment on release.
- `flush` while `partial`=1 (byte 0x55 held), then bytes 0x66, 0x77:
  - -> 0x55 is discarded.
  - -> next word is 0x6677.
  - -> `word_count` unchanged by the flush.
- `reset` pulsed low in OUT state with `word_count`=0xFFFF preloaded by 65535 transfers:
  - -> all outputs return to reset values immediately.
  - Separately, without reset, one more transfer from 0xFFFF -> `word_count` wraps to 0x0000.
